// File: rtl/count_seq_ctrl_pkg.sv
// Shared definitions for the counter sequencing controller.
//   CNT_W      : width of the downstream loadable counter (fixed at 3)
//   PASS_W_DEF : default width of the pass-count request / pass index
//   state_t    : controller state encoding
package count_seq_ctrl_pkg;

    localparam int unsigned CNT_W      = 3;
    localparam int unsigned PASS_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_COUNT = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

endpackage

// File: rtl/count_seq_ctrl_pass_counter.sv
// Pass index register for the sequencing controller.
// Ports:
//   clk       in   system clock
//   rst       in   asynchronous active-high reset
//   i_clr     in   synchronous clear of the index
//   i_inc     in   synchronous increment of the index
//   i_passes  in   effective pass count (never 0)
//   o_idx     out  current 0-based pass index
//   o_is_last out  high when o_idx is the final pass
module count_seq_ctrl_pass_counter
    import count_seq_ctrl_pkg::*;
#(
    parameter int unsigned PASS_W = PASS_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_inc,
    input  logic [PASS_W-1:0] i_passes,
    output logic [PASS_W-1:0] o_idx,
    output logic              o_is_last
);

    logic [PASS_W-1:0] r_idx;
    logic [PASS_W-1:0] w_last_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= '0;
        end else if (i_clr) begin
            r_idx <= '0;
        end else if (i_inc) begin
            r_idx <= r_idx + 1'b1;
        end
    end

    assign w_last_idx = i_passes - 1'b1;
    assign o_is_last  = (r_idx == w_last_idx);
    assign o_idx      = r_idx;

endmodule

// File: rtl/count_seq_ctrl.sv
// Sequencing controller for a 3-bit loadable counter. Runs a captured number
// of passes, each loading the captured start value and counting up to 7; the
// counter's carry-out marks the end of each pass.
// Ports:
//   clk       in   system clock
//   rst       in   asynchronous active-high reset
//   start     in   begin a sequence (accepted only in IDLE)
//   init_val  in   counter start value, captured on accepted start
//   passes    in   number of passes, captured on accepted start (0 -> 1)
//   hold      in   stall; forces cnt_en low while counting
//   co        in   counter carry-out
//   cnt_load  out  counter load strobe
//   cnt_en    out  counter enable
//   cnt_in    out  counter load value
//   busy      out  high in LOAD and COUNT
//   done      out  one-cycle pulse after the last pass
//   pass_idx  out  0-based index of the current pass
module count_seq_ctrl
    import count_seq_ctrl_pkg::*;
#(
    parameter int unsigned PASS_W = PASS_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  init_val,
    input  logic [PASS_W-1:0] passes,
    input  logic              hold,
    input  logic              co,
    output logic              cnt_load,
    output logic              cnt_en,
    output logic [CNT_W-1:0]  cnt_in,
    output logic              busy,
    output logic              done,
    output logic [PASS_W-1:0] pass_idx
);

    state_t            r_state;
    logic [CNT_W-1:0]  r_init_cap;
    logic [PASS_W-1:0] r_passes_cap;
    logic [CNT_W-1:0]  r_cnt_in;
    logic              r_cnt_load;
    logic              r_count_st;
    logic              r_busy;
    logic              r_done;

    logic              w_co_q;
    logic              w_is_last;
    logic              w_clr;
    logic              w_inc;

    // co only counts when the counter was actually enabled this cycle
    assign w_co_q = r_count_st & ~hold & co;
    assign w_clr  = (r_state == ST_IDLE) & start;
    assign w_inc  = w_co_q & ~w_is_last;

    count_seq_ctrl_pass_counter #(
        .PASS_W (PASS_W)
    ) u_pass_counter (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_clr),
        .i_inc     (w_inc),
        .i_passes  (r_passes_cap),
        .o_idx     (pass_idx),
        .o_is_last (w_is_last)
    );

    // Outputs are registered for the state being entered; r_count_st is the
    // registered COUNT decode that cnt_en is built from.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_init_cap   <= '0;
            r_passes_cap <= '0;
            r_cnt_in     <= '0;
            r_cnt_load   <= 1'b0;
            r_count_st   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_cnt_load <= 1'b0;
            r_count_st <= 1'b0;
            r_done     <= 1'b0;
            r_cnt_in   <= '0;
            case (r_state)
                ST_IDLE: begin
                    r_busy <= 1'b0;
                    if (start) begin
                        r_init_cap   <= init_val;
                        r_passes_cap <= (passes == '0) ? PASS_W'(1) : passes;
                        r_cnt_in     <= init_val;
                        r_cnt_load   <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_count_st <= 1'b1;
                    r_busy     <= 1'b1;
                    r_state    <= ST_COUNT;
                end
                ST_COUNT: begin
                    r_busy <= 1'b1;
                    if (w_co_q) begin
                        if (w_is_last) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_cnt_in   <= r_init_cap;
                            r_cnt_load <= 1'b1;
                            r_state    <= ST_LOAD;
                        end
                    end else begin
                        r_count_st <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cnt_load = r_cnt_load;
    assign cnt_en   = r_count_st & ~hold;
    assign cnt_in   = r_cnt_in;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Self-checking bench for count_seq_ctrl: a loadable 3-bit counter model
// closes the co loop, a vector table covers the directed cases, hand-written
// sequences cover start-ignore and mid-pass reset, and a randomized section
// compares every cycle against a pass/cycle trace built from the rules.
module tb_count_seq_ctrl;
    import count_seq_ctrl_pkg::*;

    localparam int unsigned PW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [2:0]    init_val;
    logic [PW-1:0] passes;
    logic          hold;
    logic          co;
    logic          cnt_load;
    logic          cnt_en;
    logic [2:0]    cnt_in;
    logic          busy;
    logic          done;
    logic [PW-1:0] pass_idx;

    always #5 clk = ~clk;

    count_seq_ctrl #(
        .PASS_W (PW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .init_val (init_val),
        .passes   (passes),
        .hold     (hold),
        .co       (co),
        .cnt_load (cnt_load),
        .cnt_en   (cnt_en),
        .cnt_in   (cnt_in),
        .busy     (busy),
        .done     (done),
        .pass_idx (pass_idx)
    );

    // Downstream counter: load has priority, co follows en.
    logic [2:0] r_cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           r_cnt <= '0;
        else if (cnt_load) r_cnt <= cnt_in;
        else if (cnt_en)   r_cnt <= r_cnt + 3'd1;
    end
    assign co = cnt_en && (r_cnt == 3'd7);

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d @%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present start for one edge; afterwards scramble the inputs to show
    // they only matter at capture. Returns in the LOAD cycle.
    task automatic do_start(input logic [2:0] iv, input logic [PW-1:0] ps);
        start    = 1'b1;
        init_val = iv;
        passes   = ps;
        step();
        start    = 1'b0;
        init_val = 3'($urandom);
        passes   = PW'($urandom);
    endtask

    // From the LOAD cycle, wait (bounded) for done and check its timing.
    task automatic finish_run(input int iv, input int lat, input int idx,
                              input int hs, input int hl);
        int got_lat  = -1;
        int got_idx  = -1;
        int busy_err = 0;
        for (int c = 0; c < 80; c++) begin
            hold = (hl > 0) && (c >= hs) && (c < hs + hl);
            #1;
            if (c == 0) begin
                check("load_strobe", int'(cnt_load), 1);
                check("load_value", int'(cnt_in), iv);
                check("first_idx", int'(pass_idx), 0);
            end
            if (done) begin
                got_lat = c;
                got_idx = int'(pass_idx);
                break;
            end
            if (!busy) busy_err++;
            step();
        end
        hold = 1'b0;
        check("done_latency", got_lat, lat);
        check("final_idx", got_idx, idx);
        check("busy_while_running", busy_err, 0);
        step();
        check("done_single", int'(done), 0);
        check("idle_busy", int'(busy), 0);
        check("idx_kept", int'(pass_idx), idx);
    endtask

    typedef struct {
        int iv;
        int ps;
        int hs;
        int hl;
        int lat;
        int idx;
    } row_t;

    typedef struct {
        bit load;
        bit en;
        bit bsy;
        bit dn;
        int cin;
        int idx;
    } exp_t;

    row_t rows[8];
    bit   hs_arr[256];
    exp_t exp_q[$];

    initial begin
        // init, passes, hold start, hold len, done latency, final idx
        rows[0] = '{5, 1,  0, 0,  4,  0};
        rows[1] = '{6, 3,  0, 0,  9,  2};
        rows[2] = '{5, 1,  2, 2,  6,  0};
        rows[3] = '{0, 0,  0, 0,  9,  0};
        rows[4] = '{7, 15, 0, 0, 30, 14};
        rows[5] = '{3, 2,  0, 0, 12,  1};
        rows[6] = '{4, 1,  0, 1,  5,  0};
        rows[7] = '{7, 1,  1, 3,  5,  0};

        rst = 1'b1; start = 1'b0; hold = 1'b0; init_val = '0; passes = '0;
        #12;
        check("rst_load", int'(cnt_load), 0);
        check("rst_en", int'(cnt_en), 0);
        check("rst_cin", int'(cnt_in), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_idx", int'(pass_idx), 0);
        @(negedge clk);
        rst = 1'b0;
        step();

        for (int r = 0; r < 8; r++) begin
            do_start(3'(rows[r].iv), PW'(rows[r].ps));
            finish_run(rows[r].iv, rows[r].lat, rows[r].idx, rows[r].hs, rows[r].hl);
        end

        // start during COUNT and DONE is ignored; accepted in the next IDLE
        do_start(3'd7, PW'(1));
        step();
        start = 1'b1; init_val = 3'd2; passes = PW'(1);
        check("seq_count_en", int'(cnt_en), 1);
        step();
        check("seq_done", int'(done), 1);
        step();
        check("seq_idle_busy", int'(busy), 0);
        check("seq_idle_load", int'(cnt_load), 0);
        step();
        start = 1'b0;
        finish_run(2, 7, 0, 0, 0);

        // asynchronous reset in the middle of pass 1
        do_start(3'd4, PW'(3));
        for (int i = 0; i < 7; i++) step();
        check("mid_idx", int'(pass_idx), 1);
        check("mid_en", int'(cnt_en), 1);
        #2 rst = 1'b1;
        #1;
        check("arst_load", int'(cnt_load), 0);
        check("arst_en", int'(cnt_en), 0);
        check("arst_cin", int'(cnt_in), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_done", int'(done), 0);
        check("arst_idx", int'(pass_idx), 0);
        step();
        check("arst_no_done", int'(done), 0);
        rst = 1'b0;
        step();
        do_start(3'd6, PW'(2));
        finish_run(6, 6, 1, 0, 0);

        // randomized: per-cycle trace built pass by pass from the rules
        for (int it = 0; it < 30; it++) begin
            int iv;
            int ps;
            int np;
            int c;
            iv = int'($urandom_range(0, 7));
            ps = int'($urandom_range(0, 5));
            np = (ps == 0) ? 1 : ps;
            for (int k = 0; k < 256; k++)
                hs_arr[k] = (k < 150) && ($urandom_range(0, 3) == 0);
            exp_q.delete();
            c = 0;
            for (int p = 0; p < np; p++) begin
                int rem;
                exp_q.push_back('{1'b1, 1'b0, 1'b1, 1'b0, iv, p});
                c++;
                rem = 8 - iv;
                while (rem > 0) begin
                    exp_q.push_back('{1'b0, !hs_arr[c], 1'b1, 1'b0, 0, p});
                    if (!hs_arr[c]) rem--;
                    c++;
                end
            end
            exp_q.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 0, np - 1});
            exp_q.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 0, np - 1});

            do_start(3'(iv), PW'(ps));
            for (int k = 0; k < exp_q.size(); k++) begin
                hold = hs_arr[k];
                #1;
                check("rnd_load", int'(cnt_load), int'(exp_q[k].load));
                check("rnd_en", int'(cnt_en), int'(exp_q[k].en));
                check("rnd_cin", int'(cnt_in), exp_q[k].cin);
                check("rnd_busy", int'(busy), int'(exp_q[k].bsy));
                check("rnd_done", int'(done), int'(exp_q[k].dn));
                check("rnd_idx", int'(pass_idx), exp_q[k].idx);
                if (k < exp_q.size() - 1) step();
            end
            hold = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
